// File: rtl/key_pio_sequencer.sv
// KEYs PIO sequencer: writes the interrupt mask, services edge captures and queues key events in a 4-deep FIFO.
// Optional feature: define KEYSEQ_POLL_EN to poll every POLL_PERIOD cycles instead of waiting for key_irq.
module key_pio_sequencer #(
    parameter logic [3:0] KEY_MASK    = 4'hF,
    parameter int         POLL_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_irq,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic [1:0]  evt_key,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        busy
);

    typedef enum logic [2:0] {INIT, IDLE, RD, SAMPLE, CLR, EMIT} state_t;

    state_t      state_reg;
    logic [3:0]  pend_reg;
    logic [1:0]  mem_reg [4];
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  count_reg;

    logic        pop;
    logic        push;
    logic        fifo_full;
    logic [1:0]  low_idx;
    logic [3:0]  pend_next;
    logic        go_rd;
    logic        unused_readdata;

    assign unused_readdata = ^avm_readdata[31:4];

    assign fifo_full = (count_reg == 3'd4);
    assign evt_valid = (count_reg != 3'd0);
    assign evt_key   = mem_reg[rd_ptr_reg];
    assign pop       = evt_valid && evt_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign push      = (state_reg == EMIT) && (pend_reg != 4'd0) && (!fifo_full || pop);

    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_reg[i]) low_idx = 2'(i);
        end
        pend_next = pend_reg & ~(4'b0001 << low_idx);
    end

`ifdef KEYSEQ_POLL_EN
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    logic [PW-1:0] poll_cnt_reg;

    assign go_rd = (poll_cnt_reg == '0);

    // Reloaded on every entry into IDLE so each idle stretch lasts a full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_reg <= PW'(POLL_PERIOD - 1);
        end else if (state_reg != IDLE) begin
            poll_cnt_reg <= PW'(POLL_PERIOD - 1);
        end else if (poll_cnt_reg != '0) begin
            poll_cnt_reg <= poll_cnt_reg - 1'b1;
        end
    end

    logic unused_irq;
    assign unused_irq = key_irq;
`else
    localparam int unused_poll_period = POLL_PERIOD;
    assign go_rd = key_irq;
`endif

    // Bus outputs are loaded on the edge that enters the state performing the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= INIT;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 2'd0;
            avm_writedata  <= 32'd0;
            pend_reg       <= 4'd0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= 2'd2;
                    avm_writedata  <= {28'd0, KEY_MASK};
                    busy           <= 1'b0;
                    state_reg      <= IDLE;
                end
                IDLE: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    if (go_rd) begin
                        avm_chipselect <= 1'b1;
                        avm_address    <= 2'd3;
                        avm_writedata  <= 32'd0;
                        busy           <= 1'b1;
                        state_reg      <= RD;
                    end
                end
                RD: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    avm_address    <= 2'd3;
                    state_reg      <= SAMPLE;
                end
                SAMPLE: begin
                    pend_reg       <= avm_readdata[3:0] & KEY_MASK;
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= 2'd3;
                    avm_writedata  <= 32'd0;
                    state_reg      <= CLR;
                end
                CLR: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    if (pend_reg != 4'd0) begin
                        state_reg <= EMIT;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                EMIT: begin
                    if (push) begin
                        pend_reg <= pend_next;
                        if (pend_next == 4'd0) begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            for (int i = 0; i < 4; i++) mem_reg[i] <= 2'd0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= low_idx;
                wr_ptr_reg          <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 3'd1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_pio_sequencer.sv
// Randomized scoreboard bench for key_pio_sequencer; includes a PIO readdata model and a masked second instance.
module tb_key_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_irq = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic [1:0]  evt_key;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic        busy;
    logic [3:0]  capture = 4'd0;

    logic        key_irq2 = 1'b0;
    logic [1:0]  avm_address2;
    logic        avm_chipselect2;
    logic        avm_write_n2;
    logic [31:0] avm_writedata2;
    logic [31:0] avm_readdata2 = 32'd0;
    logic [1:0]  evt_key2;
    logic        evt_valid2;
    logic        evt_ready2 = 1'b1;
    logic        busy2;
    logic [3:0]  capture2 = 4'd0;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } bus_t;

    bus_t       bus_q[$];
    logic [1:0] evt_q[$];

    always #5 clk = ~clk;

    key_pio_sequencer dut (
        .clk(clk), .reset(reset), .key_irq(key_irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .evt_key(evt_key), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .busy(busy)
    );

    key_pio_sequencer #(.KEY_MASK(4'b0011)) dut2 (
        .clk(clk), .reset(reset), .key_irq(key_irq2),
        .avm_address(avm_address2), .avm_chipselect(avm_chipselect2),
        .avm_write_n(avm_write_n2), .avm_writedata(avm_writedata2),
        .avm_readdata(avm_readdata2), .evt_key(evt_key2), .evt_valid(evt_valid2),
        .evt_ready(evt_ready2), .busy(busy2)
    );

    // PIO model: edge-capture register read back one cycle after the read, upper bits random.
    logic [27:0] hi_bits;
    always @(posedge clk) begin
        hi_bits = 28'($urandom());
        if (avm_chipselect && avm_write_n && avm_address == 2'd3)
            avm_readdata <= {hi_bits, capture};
        if (avm_chipselect2 && avm_write_n2 && avm_address2 == 2'd3)
            avm_readdata2 <= {hi_bits, capture2};
    end

    // Monitor: every bus access and every accepted event is checked against the scoreboard.
    always @(negedge clk) begin
        bus_t       eb;
        logic [1:0] ek;
        if (!reset) begin
            if (evt_valid && evt_ready) begin
                vectors++;
                if (evt_q.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected: got key %0d, required no event", evt_key);
                end else begin
                    ek = evt_q.pop_front();
                    if (evt_key !== ek) begin
                        errors++;
                        $display("FAIL evt_key: got %0d required %0d", evt_key, ek);
                    end else
                        $display("event key=%0d ok", evt_key);
                end
            end
            if (avm_chipselect) begin
                vectors++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got wr=%0d addr=%0d data=%0h, required idle bus",
                             !avm_write_n, avm_address, avm_writedata);
                end else begin
                    eb = bus_q.pop_front();
                    if ((!avm_write_n) !== eb.wr || avm_address !== eb.addr ||
                        (eb.wr && avm_writedata !== eb.data)) begin
                        errors++;
                        $display("FAIL bus_access: got wr=%0d addr=%0d data=%0h required wr=%0d addr=%0d data=%0h",
                                 !avm_write_n, avm_address, avm_writedata, eb.wr, eb.addr, eb.data);
                    end else
                        $display("bus wr=%0d addr=%0d data=%0h ok", eb.wr, eb.addr, eb.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else
            $display("check %s = %0h ok", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a capture produces a read, a clear write, then one event per masked set bit, low to high.
    task automatic expect_capture(input logic [3:0] pattern);
        bus_q.push_back('{wr: 1'b0, addr: 2'd3, data: 32'd0});
        bus_q.push_back('{wr: 1'b1, addr: 2'd3, data: 32'd0});
        for (int i = 0; i < 4; i++)
            if (pattern[i]) evt_q.push_back(2'(i));
        capture = pattern;
    endtask

    task automatic pulse_irq();
        key_irq = 1'b1;
        tick();
        key_irq = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_ready, input string name);
        bit done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            tick();
            if (rand_ready) evt_ready = 1'($urandom());
            if (!busy) done = 1;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: busy still 1, required 0 within 400 cycles", name);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int         lat;
        int         vcnt;
        int         ccnt;
        logic [1:0] k2;
        logic [3:0] pat;

        // Reset state
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_cs", avm_chipselect, 0);
            check("rst_wn", avm_write_n, 1);
            check("rst_addr", avm_address, 0);
            check("rst_wdata", avm_writedata, 0);
            check("rst_valid", evt_valid, 0);
            check("rst_key", evt_key, 0);
            check("rst_busy", busy, 0);
        end
        bus_q.push_back('{wr: 1'b1, addr: 2'd2, data: 32'h0000000F});
        reset = 1'b0;
        run_cycles(6);
        check("init_busy", busy, 0);
        check("init_bus_done", bus_q.size(), 0);

        // Single key, latency from irq to first evt_valid
        evt_ready = 1'b1;
        expect_capture(4'b0100);
        key_irq = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (k == 1) key_irq = 1'b0;
            if (evt_valid) lat = k;
        end
        check("latency", lat, 5);
        wait_idle(0, "single");
        run_cycles(2);

        // Three keys pop on consecutive cycles
        expect_capture(4'b1011);
        pulse_irq();
        for (int k = 0; k < 20 && !evt_valid; k++) tick();
        vcnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (evt_valid) vcnt++;
            tick();
        end
        check("consec_valid", vcnt, 3);
        check("consec_empty", evt_valid, 0);

        // No captured key: clear only
        expect_capture(4'b0000);
        pulse_irq();
        wait_idle(0, "empty_capture");
        run_cycles(3);
        check("empty_no_event", evt_valid, 0);

        // Full FIFO stall, then drain five events
        evt_ready = 1'b0;
        expect_capture(4'b1111);
        pulse_irq();
        wait_idle(0, "fill");
        expect_capture(4'b0001);
        pulse_irq();
        run_cycles(8);
        check("stall_busy", busy, 1);
        check("stall_valid", evt_valid, 1);
        evt_ready = 1'b1;
        wait_idle(0, "stall_release");
        run_cycles(4);
        check("stall_drained", evt_q.size(), 0);

        // Reset during EMIT
        evt_ready = 1'b0;
        expect_capture(4'b1111);
        pulse_irq();
        wait_idle(0, "fill2");
        expect_capture(4'b1000);
        pulse_irq();
        run_cycles(8);
        check("emit_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("abort_valid", evt_valid, 0);
        check("abort_busy", busy, 0);
        evt_q.delete();
        bus_q.push_back('{wr: 1'b1, addr: 2'd2, data: 32'h0000000F});
        reset = 1'b0;
        run_cycles(4);
        check("reinit_done", bus_q.size(), 0);

        // Randomized captures with random consumer backpressure
        for (int t = 0; t < 30; t++) begin
            pat = 4'($urandom());
            expect_capture(pat);
            pulse_irq();
            wait_idle(1, "random");
            tick();
        end
        evt_ready = 1'b1;
        run_cycles(10);
        check("random_drained", evt_q.size(), 0);
        check("random_bus_done", bus_q.size(), 0);

        // Masked instance: unmasked bits only
        capture2 = 4'b1100;
        key_irq2 = 1'b1;
        tick();
        key_irq2 = 1'b0;
        vcnt = 0;
        ccnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (evt_valid2) vcnt++;
            if (avm_chipselect2 && !avm_write_n2 && avm_address2 == 2'd3 && avm_writedata2 == 32'd0) ccnt++;
            tick();
        end
        check("mask_no_event", vcnt, 0);
        check("mask_clear_write", ccnt, 1);
        check("mask_idle", busy2, 0);
        capture2 = 4'b0110;
        key_irq2 = 1'b1;
        tick();
        key_irq2 = 1'b0;
        vcnt = 0;
        k2 = 2'd0;
        for (int k = 0; k < 12; k++) begin
            if (evt_valid2) begin
                vcnt++;
                k2 = evt_key2;
            end
            tick();
        end
        check("mask_one_event", vcnt, 1);
        check("mask_event_key", k2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/key_pio_sequencer.md
KEY_PIO_SEQUENCER -- requirements
Module: key_pio_sequencer

Interface
REQ-001 SHALL have parameter KEY_MASK, default 4'hF: interrupt mask written to the KEYs PIO and applied to captured edges.
REQ-002 SHALL have parameter POLL_PERIOD, default 1000: poll interval in clk cycles (used only under REQ-030).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_irq  input  1  irq output of the KEYs PIO.
REQ-006 avm_address  output  2  PIO register address.
REQ-007 avm_chipselect  output  1  PIO select.
REQ-008 avm_write_n  output  1  active-low write strobe.
REQ-009 avm_writedata  output  32  PIO write data.
REQ-010 avm_readdata  input  32  PIO readdata, registered by the PIO; valid the cycle after avm_address is presented.
REQ-011 evt_key  output  2  index of the pressed key at the FIFO head.
REQ-012 evt_valid  output  1  FIFO non-empty.
REQ-013 evt_ready  input  1  consumer accept; a pop occurs when evt_valid && evt_ready.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be INIT, IDLE, RD, SAMPLE, CLR, EMIT.
REQ-016 INIT, one cycle: chipselect=1, write_n=0, address=2, writedata={28'b0,KEY_MASK}; then go to IDLE.
REQ-017 IDLE: bus idle (chipselect=0, write_n=1). Go to RD when key_irq=1.
REQ-018 RD, one cycle: chipselect=1, write_n=1, address=3.
REQ-019 SAMPLE, one cycle: latch pend = avm_readdata[3:0] & KEY_MASK, with address held at 3.
REQ-020 CLR, one cycle: chipselect=1, write_n=0, address=3, writedata=0. Then go to EMIT if pend!=0, else to IDLE.
REQ-021 EMIT: when the FIFO is not full, push the index of the lowest set bit of pend and clear that bit, at most one push per cycle. Go to IDLE on the cycle the last bit is pushed.
REQ-022 EMIT with the FIFO full SHALL stall with pend unchanged. No event is ever dropped.
REQ-023 FIFO: depth 4, 2-bit entries, first-in first-out. Free count range 0..4; pointers wrap modulo 4.
REQ-024 A push and a pop in the same cycle on a full FIFO SHALL both succeed; occupancy stays 4.
REQ-025 Latency: from key_irq rising in IDLE to first evt_valid on an empty FIFO = 5 cycles (RD, SAMPLE, CLR, push, visible).
REQ-026 An edge detected by the PIO during the CLR cycle is cleared by the PIO. This loss is accepted and documented; edges arriving in any other state are serviced on the next IDLE.
REQ-027 Bus outputs SHALL be registered: no combinational path from inputs to avm_* outputs.

Reset
REQ-028 Reset values: state=INIT, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, pend=0, FIFO empty (evt_valid=0, evt_key=0), busy=0.
REQ-029 Reset asserted in any state SHALL abort the sequence and flush the FIFO. INIT re-executes on the first cycle after reset deasserts.

Configuration
REQ-030 Macro KEYSEQ_POLL_EN, when defined: IDLE ignores key_irq and goes to RD each time a POLL_PERIOD-cycle counter wraps. The counter reloads on entering IDLE. INIT still writes the mask.
REQ-031 Macro KEYSEQ_POLL_EN, when undefined: interrupt-driven per REQ-017. No poll counter is synthesised.

Verification
REQ-032 Reset release -> exactly one write, address 2, data 0x0000000F, then the bus stays idle with busy=0.
REQ-033 key_irq=1, readdata[3:0]=4'b0100 in SAMPLE -> read addr 3, write addr 3 data 0, then a single event evt_key=2, with first evt_valid 5 cycles after irq.
REQ-034 readdata=4'b1011, evt_ready=1 -> events 0,1,3 in order on consecutive cycles.
REQ-035 FIFO pre-filled with 4 events, evt_ready=0, capture 4'b0001 -> EMIT stalls with busy=1. Raise evt_ready -> 5 events out, the last being 0.
REQ-036 KEY_MASK=4'b0011, readdata=4'b1100 -> clear write occurs, no event, return to IDLE.
REQ-037 Assert reset during EMIT with pend=4'b1000 -> evt_valid=0 next cycle, then the INIT write repeats.
